// File: rtl/id_regfile_fwd_pkg.sv
// Shared widths and constants for the ID-stage operand block.
// COMMON_WIDTH  : default data width
// REG_NUM_WIDTH : default register index width
// REG_NUM       : default architectural register count
// ZERO_REG      : index of the hardwired-zero register
package id_regfile_fwd_pkg;

  localparam int unsigned COMMON_WIDTH  = 32;
  localparam int unsigned REG_NUM_WIDTH = 5;
  localparam int unsigned REG_NUM       = 32;
  localparam int unsigned ZERO_REG      = 0;

endpackage

// File: rtl/id_regfile_fwd_if.sv
// Pipeline-side bundle for the ID-stage operand block.
// master : pipeline (drives reads, forwards, writeback, issue; sees operands/stall)
// slave  : register file (returns operands, stall, pending count)
interface id_regfile_fwd_if #(
  parameter int unsigned DATA_W   = id_regfile_fwd_pkg::COMMON_WIDTH,
  parameter int unsigned ADDR_W   = id_regfile_fwd_pkg::REG_NUM_WIDTH,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned NUM_FWD  = 2
) ();

  logic [NUM_READ-1:0]        rd_en;
  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [NUM_FWD-1:0]         fwd_ce;
  logic [NUM_FWD*ADDR_W-1:0]  fwd_reg;
  logic [NUM_FWD*DATA_W-1:0]  fwd_data;
  logic                       wb_ce;
  logic [ADDR_W-1:0]          wb_reg;
  logic [DATA_W-1:0]          wb_data;
  logic                       iss_ce;
  logic                       iss_load;
  logic [ADDR_W-1:0]          iss_rd;
  logic                       stall;
  logic [ADDR_W:0]            pend_cnt;

  modport master (
    output rd_en, rd_addr, fwd_ce, fwd_reg, fwd_data,
           wb_ce, wb_reg, wb_data, iss_ce, iss_load, iss_rd,
    input  rd_data, stall, pend_cnt
  );

  modport slave (
    input  rd_en, rd_addr, fwd_ce, fwd_reg, fwd_data,
           wb_ce, wb_reg, wb_data, iss_ce, iss_load, iss_rd,
    output rd_data, stall, pend_cnt
  );

endinterface

// File: rtl/id_operand_mux.sv
// Per-read-port operand resolution: x0 / out-of-range, forward channels
// (lowest index wins), WB write-through, then the register array.
// rst       : forces a zero operand
// rd_addr   : register index read by this port
// fwd_*     : forwarding channels, index 0 youngest
// wb_*      : writeback bus
// arr_data  : array contents at rd_addr (already zero when out of range)
// rd_data_c : resolved operand (combinational)
// hit_c     : a forward or WB supplies this index this cycle
module id_operand_mux #(
  parameter int unsigned DATA_W  = id_regfile_fwd_pkg::COMMON_WIDTH,
  parameter int unsigned ADDR_W  = id_regfile_fwd_pkg::REG_NUM_WIDTH,
  parameter int unsigned REG_NUM = id_regfile_fwd_pkg::REG_NUM,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [NUM_FWD-1:0]        fwd_ce,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_reg,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      wb_ce,
  input  logic [ADDR_W-1:0]         wb_reg,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic [DATA_W-1:0]         arr_data,
  output logic [DATA_W-1:0]         rd_data_c,
  output logic                      hit_c
);

  import id_regfile_fwd_pkg::*;

  logic valid_c;

  // Sources applied lowest priority first so the later, higher-priority
  // match overwrites; the channel loop runs downward so channel 0 lands last.
  always_comb begin
    rd_data_c = '0;
    hit_c     = 1'b0;
    valid_c   = !rst && (rd_addr != ADDR_W'(ZERO_REG)) && (32'(rd_addr) < REG_NUM);
    if (valid_c) begin
      rd_data_c = arr_data;
      if (wb_ce && (wb_reg == rd_addr)) begin
        rd_data_c = wb_data;
        hit_c     = 1'b1;
      end
      for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
        if (fwd_ce[k] && (fwd_reg[k*ADDR_W +: ADDR_W] == rd_addr)) begin
          rd_data_c = fwd_data[k*DATA_W +: DATA_W];
          hit_c     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_regfile_fwd.sv
// ID-stage integer register file with prioritised forwarding, WB
// write-through and a load-use scoreboard.
// clk : clock
// rst : synchronous active-high reset
// bus : slave side of id_regfile_fwd_if (reads, forwards, WB, issue,
//       operands, stall, pending-load count)
module id_regfile_fwd #(
  parameter int unsigned DATA_W   = id_regfile_fwd_pkg::COMMON_WIDTH,
  parameter int unsigned REG_NUM  = id_regfile_fwd_pkg::REG_NUM,
  parameter int unsigned ADDR_W   = id_regfile_fwd_pkg::REG_NUM_WIDTH,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned NUM_FWD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  id_regfile_fwd_if.slave  bus
);

  import id_regfile_fwd_pkg::*;

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]          regs [REG_NUM];
  logic [REG_NUM-1:0]         pend;
  logic [REG_NUM-1:0]         pend_nxt_c;
  logic [CNT_W-1:0]           cnt_nxt_c;
  logic [CNT_W-1:0]           pend_cnt;
  logic [NUM_READ-1:0]        port_stall_c;
  logic [NUM_READ*DATA_W-1:0] rd_data_c;
  logic                       stall_c;
  logic                       wb_ok_c;
  logic                       set_ok_c;

  assign wb_ok_c  = bus.wb_ce && (bus.wb_reg != ADDR_W'(ZERO_REG)) &&
                    (32'(bus.wb_reg) < REG_NUM);
  assign set_ok_c = bus.iss_ce && bus.iss_load && !stall_c &&
                    (bus.iss_rd != ADDR_W'(ZERO_REG)) && (32'(bus.iss_rd) < REG_NUM);

  // Register array; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(REG_NUM); r++) begin
        regs[r] <= '0;
      end
    end else if (wb_ok_c) begin
      regs[bus.wb_reg] <= bus.wb_data;
    end
  end

  // Read ports: array lookup, operand resolution and per-port hazard.
  for (genvar i = 0; i < int'(NUM_READ); i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              in_range;
    logic [DATA_W-1:0] arr;
    logic              hit;

    assign addr     = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign in_range = 32'(addr) < REG_NUM;
    assign arr      = in_range ? regs[addr] : '0;

    id_operand_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .REG_NUM (REG_NUM),
      .NUM_FWD (NUM_FWD)
    ) u_mux (
      .rst       (rst),
      .rd_addr   (addr),
      .fwd_ce    (bus.fwd_ce),
      .fwd_reg   (bus.fwd_reg),
      .fwd_data  (bus.fwd_data),
      .wb_ce     (bus.wb_ce),
      .wb_reg    (bus.wb_reg),
      .wb_data   (bus.wb_data),
      .arr_data  (arr),
      .rd_data_c (rd_data_c[i*DATA_W +: DATA_W]),
      .hit_c     (hit)
    );

    // A same-cycle forward or WB of the pending register resolves the hazard.
    assign port_stall_c[i] = bus.rd_en[i] && in_range &&
                             (addr != ADDR_W'(ZERO_REG)) && pend[addr] && !hit;
  end

  assign stall_c     = !rst && (|port_stall_c);
  assign bus.stall   = stall_c;
  assign bus.rd_data = rd_data_c;

  // Next pending set: WB clears, then a new load sets (newer load wins).
  always_comb begin
    pend_nxt_c = pend;
    cnt_nxt_c  = '0;
    if (wb_ok_c) begin
      pend_nxt_c[bus.wb_reg] = 1'b0;
    end
    if (set_ok_c) begin
      pend_nxt_c[bus.iss_rd] = 1'b1;
    end
    pend_nxt_c[ZERO_REG] = 1'b0;
    for (int r = 0; r < int'(REG_NUM); r++) begin
      cnt_nxt_c = cnt_nxt_c + CNT_W'(pend_nxt_c[r]);
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt_c;
      pend_cnt <= cnt_nxt_c;
    end
  end

  assign bus.pend_cnt = pend_cnt;

endmodule

// File: tb/tb_id_regfile_fwd.sv
// Self-checking bench for id_regfile_fwd: directed steps followed by a
// randomized run, all checked against a behavioural model of the register
// file and load scoreboard.
module tb_id_regfile_fwd;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NF = 2;
  localparam int RN = 32;

  logic clk = 1'b0;
  logic rst;

  id_regfile_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .NUM_FWD(NF)) bus ();

  id_regfile_fwd #(
    .DATA_W(DW), .REG_NUM(RN), .ADDR_W(AW), .NUM_READ(NR), .NUM_FWD(NF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_regs [RN];
  bit            m_pend [RN];
  int            checks   = 0;
  int            failures = 0;

  function automatic bit m_hit(input int a);
    for (int k = 0; k < NF; k++)
      if (bus.fwd_ce[k] && int'(bus.fwd_reg[k*AW +: AW]) == a) return 1'b1;
    return bus.wb_ce && int'(bus.wb_reg) == a;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int p);
    int a;
    a = int'(bus.rd_addr[p*AW +: AW]);
    if (rst || a == 0) return '0;
    for (int k = 0; k < NF; k++)
      if (bus.fwd_ce[k] && int'(bus.fwd_reg[k*AW +: AW]) == a) return bus.fwd_data[k*DW +: DW];
    if (bus.wb_ce && int'(bus.wb_reg) == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_stall();
    int a;
    if (rst) return 1'b0;
    for (int p = 0; p < NR; p++) begin
      a = int'(bus.rd_addr[p*AW +: AW]);
      if (bus.rd_en[p] && a != 0 && m_pend[a] && !m_hit(a)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < RN; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic model_edge();
    bit st;
    st = exp_stall();
    if (rst) begin
      for (int r = 0; r < RN; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      if (bus.wb_ce && bus.wb_reg != 0) m_regs[bus.wb_reg] = bus.wb_data;
      if (bus.wb_ce) m_pend[bus.wb_reg] = 1'b0;
      if (bus.iss_ce && bus.iss_load && bus.iss_rd != 0 && !st) m_pend[bus.iss_rd] = 1'b1;
    end
  endtask

  task automatic idle();
    bus.rd_en = '0;  bus.rd_addr = '0;
    bus.fwd_ce = '0; bus.fwd_reg = '0; bus.fwd_data = '0;
    bus.wb_ce = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.iss_ce = 1'b0; bus.iss_load = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic set_rd(input int p, input int a, input bit en);
    bus.rd_addr[p*AW +: AW] = AW'(a);
    bus.rd_en[p] = en;
  endtask

  task automatic set_fwd(input int k, input int r, input logic [DW-1:0] d);
    bus.fwd_ce[k] = 1'b1;
    bus.fwd_reg[k*AW +: AW] = AW'(r);
    bus.fwd_data[k*DW +: DW] = d;
  endtask

  task automatic set_wb(input int r, input logic [DW-1:0] d);
    bus.wb_ce = 1'b1; bus.wb_reg = AW'(r); bus.wb_data = d;
  endtask

  task automatic set_iss(input bit ld, input int r);
    bus.iss_ce = 1'b1; bus.iss_load = ld; bus.iss_rd = AW'(r);
  endtask

  // Check combinational outputs before the edge and pend_cnt after it.
  task automatic cycle(input string tag);
    logic [DW-1:0] e;
    bit es;
    int ec;
    #1;
    for (int p = 0; p < NR; p++) begin
      e = exp_read(p);
      checks++;
      assert (bus.rd_data[p*DW +: DW] === e) else begin
        failures++;
        $error("FAIL %s rd_data[%0d] observed=%h expected=%h", tag, p, bus.rd_data[p*DW +: DW], e);
      end
    end
    es = exp_stall();
    checks++;
    assert (bus.stall === es) else begin
      failures++;
      $error("FAIL %s stall observed=%b expected=%b", tag, bus.stall, es);
    end
    @(posedge clk);
    model_edge();
    #1;
    ec = exp_cnt();
    checks++;
    assert (bus.pend_cnt === (AW+1)'(ec)) else begin
      failures++;
      $error("FAIL %s pend_cnt observed=%0d expected=%0d", tag, bus.pend_cnt, ec);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < RN; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    rst = 1'b1;
    idle();
    @(negedge clk);

    // Reset, then basic write and read-back.
    set_rd(0, 1, 1'b0); set_rd(1, 2, 1'b0);
    cycle("reset");
    rst = 1'b0;
    cycle("post_reset_read");
    idle(); set_rd(0, 1, 1'b0); set_wb(1, 32'd3);
    cycle("wb_through_x1");
    idle(); set_rd(0, 1, 1'b0);
    cycle("array_x1");

    // Forward priority over WB over the array.
    idle(); set_rd(0, 1, 1'b0); set_rd(1, 1, 1'b0);
    set_fwd(0, 1, 32'd20); set_fwd(1, 1, 32'd10);
    cycle("fwd0_wins");
    bus.fwd_ce[0] = 1'b0;
    cycle("fwd1_only");
    idle(); set_rd(0, 1, 1'b0); set_wb(1, 32'd7);
    cycle("wb_through_7");
    idle(); set_rd(0, 1, 1'b0);
    cycle("array_7");

    // x0 ignores forwards and writes.
    idle(); set_rd(0, 0, 1'b1); set_rd(1, 0, 1'b0);
    set_fwd(0, 0, 32'd55); set_fwd(1, 0, 32'd55); set_wb(0, 32'd55);
    cycle("x0_targeted");
    idle(); set_rd(0, 0, 1'b1);
    cycle("x0_after");

    // Load-use hazard and its resolution.
    idle(); set_iss(1'b1, 5);
    cycle("issue_load_x5");
    idle(); set_rd(0, 5, 1'b1);
    cycle("stall_x5");
    idle(); set_rd(0, 5, 1'b1); set_fwd(1, 5, 32'd42);
    cycle("fwd_clears_stall");
    idle(); set_rd(0, 5, 1'b1); set_wb(5, 32'd42);
    cycle("wb_clears_pend");
    idle(); set_rd(0, 5, 1'b1);
    cycle("x5_settled");

    // Same-edge set and clear; issue during stall.
    idle(); set_iss(1'b1, 6);
    cycle("issue_load_x6");
    idle(); set_wb(6, 32'd9); set_iss(1'b1, 6);
    cycle("set_beats_clear");
    idle(); set_rd(1, 6, 1'b1); set_iss(1'b1, 7);
    cycle("issue_while_stall");
    idle(); set_iss(1'b0, 6);
    cycle("nonload_keeps_pend");
    idle(); set_wb(6, 32'd11);
    cycle("wb_clears_x6");

    // Reset in the middle of pending loads.
    idle(); set_iss(1'b1, 3);
    cycle("issue_load_x3");
    idle(); set_iss(1'b1, 4);
    cycle("issue_load_x4");
    idle(); rst = 1'b1; set_rd(0, 3, 1'b1); set_rd(1, 4, 1'b1);
    cycle("mid_reset");
    rst = 1'b0;
    for (int r = 0; r < RN; r += 2) begin
      idle(); set_rd(0, r, 1'b1); set_rd(1, r + 1, 1'b1);
      cycle("regs_cleared");
    end

    // Randomized traffic over a small register window to provoke hits.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NR; p++) set_rd(p, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < NF; k++)
        if ($urandom_range(0, 3) == 0) set_fwd(k, int'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) set_wb(int'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 0) set_iss(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
